// File: rtl/acc_sequencer_pkg.sv
// rtl/acc_sequencer_pkg.sv - command and state encodings shared by the sequencer and its bench
package acc_sequencer_pkg;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_AND = 3'd1;
    localparam logic [2:0] CMD_LDA = 3'd2;
    localparam logic [2:0] CMD_CMA = 3'd3;
    localparam logic [2:0] CMD_CIR = 3'd4;
    localparam logic [2:0] CMD_CIL = 3'd5;
    localparam logic [2:0] CMD_CLA = 3'd6;
    localparam logic [2:0] CMD_CLE = 3'd7;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_FETCH_ENC = 2'd1;
    localparam logic [1:0] ST_EXEC_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_FETCH = ST_FETCH_ENC,
        ST_EXEC  = ST_EXEC_ENC
    } state_t;

    // Only the memory-reference commands need an operand word before executing.
    function automatic logic needs_operand(input logic [2:0] c);
        return (c == CMD_ADD) || (c == CMD_AND) || (c == CMD_LDA);
    endfunction

endpackage

// File: rtl/acc_sequencer_if.sv
// rtl/acc_sequencer_if.sv - command, operand-fetch and status signals of the accumulator sequencer
interface acc_sequencer_if #(parameter int W = 4);

    logic         cmd_valid;
    logic [2:0]   cmd;
    logic         cmd_ready;
    logic         rd_req;
    logic         rd_ack;
    logic [W-1:0] rd_data;
    logic [W-1:0] ac;
    logic         e;
    logic         n;
    logic         z;
    logic         ovf;
    logic         done;

    modport master (
        output cmd_valid, cmd, rd_ack, rd_data,
        input  cmd_ready, rd_req, ac, e, n, z, ovf, done
    );

    modport slave (
        input  cmd_valid, cmd, rd_ack, rd_data,
        output cmd_ready, rd_req, ac, e, n, z, ovf, done
    );

endinterface

// File: rtl/acc_sequencer_alu.sv
// rtl/acc_sequencer_alu.sv - combinational ALU producing the next AC and E for one command
module ALU
    import acc_sequencer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         e_in,
    output logic [W-1:0] res,
    output logic         e_out
);

    always_comb begin
        res   = a;
        e_out = e_in;
        case (op)
            CMD_ADD: {e_out, res} = {1'b0, a} + {1'b0, b};
            CMD_AND: res = a & b;
            CMD_LDA: res = b;
            CMD_CMA: res = ~a;
            CMD_CIR: begin
                res   = {e_in, a[W-1:1]};
                e_out = a[0];
            end
            CMD_CIL: begin
                res   = {a[W-2:0], e_in};
                e_out = a[W-1];
            end
            CMD_CLA: res = '0;
            CMD_CLE: e_out = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - IDLE/FETCH/EXEC sequencer owning AC, E, DR and the status flags
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst,
    acc_sequencer_if.slave bus
);

    state_t       state_q, state_d;
    logic [2:0]   cmd_q, cmd_d;
    logic [W-1:0] dr_q, dr_d;
    logic [W-1:0] ac_q, ac_d;
    logic         e_q, e_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;

    logic [W-1:0] alu_res;
    logic         alu_e;

    ALU #(.W(W)) u_alu (
        .op    (cmd_q),
        .a     (ac_q),
        .b     (dr_q),
        .e_in  (e_q),
        .res   (alu_res),
        .e_out (alu_e)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            e_q     <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            e_q     <= e_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        dr_d    = dr_q;
        ac_d    = ac_q;
        e_d     = e_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd;
                    state_d = needs_operand(bus.cmd) ? ST_FETCH : ST_EXEC;
                end
            end
            ST_FETCH: begin
                if (bus.rd_ack) begin
                    dr_d    = bus.rd_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ac_d    = alu_res;
                e_d     = alu_e;
                // Signed overflow: like-signed operands whose sum flips sign.
                ovf_d   = (cmd_q == CMD_ADD) && (ac_q[W-1] == dr_q[W-1])
                          && (alu_res[W-1] != ac_q[W-1]);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rd_req    = (state_q == ST_FETCH);
    assign bus.ac        = ac_q;
    assign bus.e         = e_q;
    assign bus.n         = ac_q[W-1];
    assign bus.z         = (ac_q == '0);
    assign bus.ovf       = ovf_q;
    assign bus.done      = done_q;

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 SHALL have parameter W, default 4, meaning datapath width of AC, DR, operand bus.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd  input  3  command: 0 ADD, 1 AND, 2 LDA, 3 CMA, 4 CIR, 5 CIL, 6 CLA, 7 CLE.
REQ-006 SHALL have port cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port rd_req  output  1  operand fetch request, held until acknowledged.
REQ-008 SHALL have port rd_ack  input  1  operand valid on rd_data this cycle.
REQ-009 SHALL have port rd_data  input  W  operand word.
REQ-010 SHALL have port ac  output  W  accumulator register.
REQ-011 SHALL have port e  output  1  extend (carry) register.
REQ-012 SHALL have ports n, z, ovf, done  output  1 each: ac[W-1]; ac==0; registered signed-overflow flag; one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, FETCH, EXEC.
REQ-014 IDLE: on accept, SHALL latch cmd; ADD/AND/LDA -> FETCH, all others -> EXEC.
REQ-015 FETCH: SHALL drive rd_req=1 every cycle; on rd_ack SHALL load DR<=rd_data and go EXEC; no timeout.
REQ-016 EXEC: exactly one cycle; SHALL drive ALU op from latched cmd with AC, DR, E operands, then return to IDLE.
REQ-017 At EXEC edge: ADD AC<=AC+DR mod 2^W, E<=carry-out; AND AC<=AC&DR; LDA AC<=DR; CMA AC<=~AC; E unchanged for AND/LDA/CMA.
REQ-018 At EXEC edge: CIR AC<={E,AC[W-1:1]}, E<=AC[0]; CIL AC<={AC[W-2:0],E}, E<=AC[W-1]; CLA AC<=0; CLE E<=0.
REQ-019 ovf SHALL be set at EXEC edge of ADD iff AC[W-1]==DR[W-1] and sum[W-1]!=AC[W-1]; cleared at EXEC edge of any other command; computed here, not taken from the ALU flag.
REQ-020 done SHALL be high exactly the cycle after EXEC, coincident with updated ac/e and cmd_ready=1.
REQ-021 Latency accept->done: 2 cycles for register commands; 2 cycles plus FETCH cycles for memory commands (min 3 with rd_ack in first FETCH cycle).
REQ-022 cmd_valid while cmd_ready=0 SHALL be ignored, no queuing.
REQ-023 rd_ack outside FETCH SHALL be ignored; DR unchanged.
REQ-024 A new command SHALL be acceptable in the same cycle done is high.
REQ-025 n and z SHALL be combinational from registered ac.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, ac=0, e=0, DR=0, ovf=0, done=0, rd_req=0, latched cmd=0.
REQ-027 rst asserted mid-FETCH or mid-EXEC SHALL abort with no register update; a later rd_ack SHALL be ignored.
REQ-028 After rst release cmd_ready SHALL be 1 on the first cycle.

Structure
REQ-029 Command encodings and state encodings SHALL be localparams in a shared package/header used by sequencer and bench.
REQ-030 SHALL instantiate one sub-module: the team ALU (module ALU, parameter W), for result and carry; state machine and registers in this block.

Verification
REQ-031 LDA, rd_data=4'h9, rd_ack two cycles after rd_req -> ac=9, e unchanged, n=1, z=0, done one pulse, rd_req low after ack.
REQ-032 ac=4'hF, e=0, ADD with DR=1 -> ac=0, e=1, z=1, ovf=0; then ac=7, ADD DR=1 -> ac=8, e=0, ovf=1, n=1.
REQ-033 ac=4'b1011, e=0: CIR -> ac=4'b0101, e=1; then CIL -> ac=4'b1011, e=0.
REQ-034 CLA, CMA back-to-back with cmd_valid held -> ac=0 then 4'hF, each done 2 cycles after accept, second accepted in first done cycle.
REQ-035 rst asserted during FETCH, rd_ack after release -> all outputs reset values, ac stays 0, no done.
REQ-036 cmd_valid toggled during FETCH with cmd=CLA -> ignored; original ADD completes correctly.
